// File: rtl/adder_share_ctrl_pkg.sv
// Shared types and constants for the two-requester shared 4-bit adder.
// Optional macro ADD_SAT_EN: when defined, an adder carry-out saturates the sum to 4'hF.
package adder_share_ctrl_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned RES_W = OP_W + 1;
    localparam int unsigned SEG_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } operand_t;

    // Active-low segment patterns, bit0 = a ... bit6 = g, indexed by hex digit
    localparam logic [SEG_W-1:0] SEG_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // {cout, sum} of two operands with carry-in 0; saturates on carry when ADD_SAT_EN is set
    function automatic logic [RES_W-1:0] add_result(input logic [OP_W-1:0] a,
                                                    input logic [OP_W-1:0] b);
        logic [RES_W-1:0] raw;
        raw = RES_W'(a) + RES_W'(b);
`ifdef ADD_SAT_EN
        if (raw[OP_W]) begin
            raw = {1'b1, {OP_W{1'b1}}};
        end
`else
        raw = raw;
`endif
        return raw;
    endfunction

endpackage

// File: rtl/adder_share_ctrl_if.sv
// Request/grant/result bundle between two requesters and the shared adder.
interface adder_share_ctrl_if
    import adder_share_ctrl_pkg::*;
();

    logic              req0;
    logic              req1;
    logic [OP_W-1:0]   a0;
    logic [OP_W-1:0]   b0;
    logic [OP_W-1:0]   a1;
    logic [OP_W-1:0]   b1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic [OP_W-1:0]   sum;
    logic              cout;
    logic [SEG_W-1:0]  seg_out;

    modport master (
        output req0, req1, a0, b0, a1, b1,
        input  gnt0, gnt1, done0, done1, sum, cout, seg_out
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1,
        output gnt0, gnt1, done0, done1, sum, cout, seg_out
    );

endinterface

// File: rtl/adder_share_ctrl_seg7_decode.sv
// Hex digit to active-low 7-segment pattern (bit0 = a ... bit6 = g), purely combinational.
module seg7_decode
    import adder_share_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]  digit_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_LUT[digit_i];
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin arbiter sharing one 4-bit adder between two 4-phase requesters.
// Optional macro ADD_SAT_EN (via package add_result): saturate sum to 4'hF on carry-out.
module adder_share_ctrl
    import adder_share_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    adder_share_ctrl_if.slave  bus
);

    state_e            state_q, state_d;
    logic              winner_q, winner_d;
    logic              last_served_q, last_served_d;
    operand_t          opnd_q, opnd_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic [OP_W-1:0]   sum_q, sum_d;
    logic              cout_q, cout_d;

    logic              any_req_c;
    logic              pick_c;
    logic              win_req_c;
    logic [SEG_W-1:0]  seg_c;

    // On a tie the requester not served last wins; a lone requester always wins
    assign any_req_c = bus.req0 | bus.req1;
    assign pick_c    = (bus.req0 & bus.req1) ? ~last_served_q : bus.req1;
    assign win_req_c = winner_q ? bus.req1 : bus.req0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_req_c)  state_d = ST_CALC;
            ST_CALC:                 state_d = ST_DONE;
            ST_DONE: if (!win_req_c) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        winner_d      = winner_q;
        last_served_d = last_served_q;
        opnd_d        = opnd_q;
        gnt0_d        = gnt0_q;
        gnt1_d        = gnt1_q;
        done0_d       = done0_q;
        done1_d       = done1_q;
        sum_d         = sum_q;
        cout_d        = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_c) begin
                    winner_d = pick_c;
                    opnd_d   = pick_c ? '{a: bus.a1, b: bus.b1} : '{a: bus.a0, b: bus.b0};
                    gnt0_d   = ~pick_c;
                    gnt1_d   = pick_c;
                end
            end
            ST_CALC: begin
                {cout_d, sum_d} = add_result(opnd_q.a, opnd_q.b);
                done0_d = ~winner_q;
                done1_d = winner_q;
            end
            ST_DONE: begin
                // Completion is recognised only once the winner releases its request
                if (!win_req_c) begin
                    gnt0_d        = 1'b0;
                    gnt1_d        = 1'b0;
                    done0_d       = 1'b0;
                    done1_d       = 1'b0;
                    last_served_d = winner_q;
                end
            end
            default: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                done0_d = 1'b0;
                done1_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            winner_q      <= 1'b0;
            last_served_q <= 1'b1;
            opnd_q        <= '0;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            sum_q         <= '0;
            cout_q        <= 1'b0;
        end else begin
            winner_q      <= winner_d;
            last_served_q <= last_served_d;
            opnd_q        <= opnd_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            done0_q       <= done0_d;
            done1_q       <= done1_d;
            sum_q         <= sum_d;
            cout_q        <= cout_d;
        end
    end

    seg7_decode u_seg7_decode (
        .digit_i (sum_q),
        .seg_o   (seg_c)
    );

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.done0   = done0_q;
    assign bus.done1   = done1_q;
    assign bus.sum     = sum_q;
    assign bus.cout    = cout_q;
    assign bus.seg_out = seg_c;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed self-checking bench for adder_share_ctrl: vector table plus multi-cycle corner sequences.
module tb_adder_share_ctrl;

    logic clk;
    logic resetn;
    int   total;
    int   bad;

`ifdef ADD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    adder_share_ctrl_if bus ();

    adder_share_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         who;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sum_wrap;
        logic [3:0] sum_sat;
        bit         cout;
        logic [6:0] seg_wrap;
        logic [6:0] seg_sat;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt0"},  32'(bus.gnt0),  32'd0);
        check({tag, "_gnt1"},  32'(bus.gnt1),  32'd0);
        check({tag, "_done0"}, 32'(bus.done0), 32'd0);
        check({tag, "_done1"}, 32'(bus.done1), 32'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();
    endtask

    // Fail on any cycle where both grants are high
    always @(negedge clk) begin
        if (resetn && bus.gnt0 && bus.gnt1) begin
            bad++;
            total++;
            $display("FAIL gnt_exclusive: got gnt0=1 gnt1=1 expected at most one at %0t", $time);
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        resetn = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = 4'h0; bus.b0 = 4'h0; bus.a1 = 4'h0; bus.b1 = 4'h0;

        vecs[0] = '{1'b0, 4'h3, 4'h2, 4'h5, 4'h5, 1'b0, 7'b0010010, 7'b0010010};
        vecs[1] = '{1'b1, 4'h9, 4'h8, 4'h1, 4'hF, 1'b1, 7'b1111001, 7'b0001110};
        vecs[2] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 7'b1000000, 7'b1000000};
        vecs[3] = '{1'b0, 4'hF, 4'h1, 4'h0, 4'hF, 1'b1, 7'b1000000, 7'b0001110};
        vecs[4] = '{1'b1, 4'h7, 4'h1, 4'h8, 4'h8, 1'b0, 7'b0000000, 7'b0000000};
        vecs[5] = '{1'b1, 4'hF, 4'hF, 4'hE, 4'hF, 1'b1, 7'b0000110, 7'b0001110};
        vecs[6] = '{1'b0, 4'hA, 4'h3, 4'hD, 4'hD, 1'b0, 7'b0100001, 7'b0100001};

        // Reset state
        #2;
        check_idle_outputs("reset");
        check("reset_sum",  32'(bus.sum),     32'd0);
        check("reset_cout", 32'(bus.cout),    32'd0);
        check("reset_seg",  32'(bus.seg_out), 32'b1000000);
        @(negedge clk);
        resetn = 1'b1;
        step();

        // Tie after reset: requester 0 first, then requester 1
        bus.a0 = 4'h1; bus.b0 = 4'h1; bus.a1 = 4'h2; bus.b1 = 4'h3;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        step();
        check("tie_gnt0", 32'(bus.gnt0), 32'd1);
        check("tie_gnt1", 32'(bus.gnt1), 32'd0);
        step();
        check("tie_done0", 32'(bus.done0), 32'd1);
        check("tie_sum0",  32'(bus.sum),   32'd2);
        step();
        step();
        check("tie_hold_gnt0",  32'(bus.gnt0),  32'd1);
        check("tie_hold_done0", 32'(bus.done0), 32'd1);
        bus.req0 = 1'b0;
        step();
        check_idle_outputs("tie_release");
        step();
        check("tie_gnt1_next", 32'(bus.gnt1), 32'd1);
        check("tie_gnt0_off",  32'(bus.gnt0), 32'd0);
        step();
        check("tie_done1", 32'(bus.done1), 32'd1);
        check("tie_sum1",  32'(bus.sum),   32'd5);
        bus.req1 = 1'b0;
        step();
        check_idle_outputs("tie_end");
        step();

        // Vector table: one single-requester transaction per row
        for (int i = 0; i < 7; i++) begin
            logic [3:0] es;
            logic [6:0] eg;
            es = SAT ? vecs[i].sum_sat : vecs[i].sum_wrap;
            eg = SAT ? vecs[i].seg_sat : vecs[i].seg_wrap;
            if (vecs[i].who) begin
                bus.a1 = vecs[i].a; bus.b1 = vecs[i].b;
                bus.a0 = ~vecs[i].a; bus.b0 = 4'h6;
                bus.req1 = 1'b1;
            end else begin
                bus.a0 = vecs[i].a; bus.b0 = vecs[i].b;
                bus.a1 = ~vecs[i].b; bus.b1 = 4'h9;
                bus.req0 = 1'b1;
            end
            step();
            check($sformatf("v%0d_gnt_win", i),  32'(vecs[i].who ? bus.gnt1 : bus.gnt0), 32'd1);
            check($sformatf("v%0d_gnt_lose", i), 32'(vecs[i].who ? bus.gnt0 : bus.gnt1), 32'd0);
            check($sformatf("v%0d_done_early", i), 32'(vecs[i].who ? bus.done1 : bus.done0), 32'd0);
            step();
            check($sformatf("v%0d_done", i), 32'(vecs[i].who ? bus.done1 : bus.done0), 32'd1);
            check($sformatf("v%0d_sum", i),  32'(bus.sum),     32'(es));
            check($sformatf("v%0d_cout", i), 32'(bus.cout),    32'(vecs[i].cout));
            check($sformatf("v%0d_seg", i),  32'(bus.seg_out), 32'(eg));
            bus.req0 = 1'b0; bus.req1 = 1'b0;
            step();
            check_idle_outputs($sformatf("v%0d_rel", i));
            check($sformatf("v%0d_sum_hold", i), 32'(bus.sum), 32'(es));
            step();
        end

        // Early drop during CALC with requester 1 waiting
        bus.a0 = 4'h4; bus.b0 = 4'h4; bus.a1 = 4'h1; bus.b1 = 4'h2;
        bus.req0 = 1'b1;
        step();
        check("early_gnt0", 32'(bus.gnt0), 32'd1);
        bus.req0 = 1'b0; bus.req1 = 1'b1;
        step();
        check("early_done0", 32'(bus.done0), 32'd1);
        check("early_sum",   32'(bus.sum),   32'd8);
        check("early_gnt1_wait", 32'(bus.gnt1), 32'd0);
        step();
        check_idle_outputs("early_idle");
        step();
        check("early_gnt1", 32'(bus.gnt1), 32'd1);
        step();
        check("early_done1", 32'(bus.done1), 32'd1);
        check("early_sum1",  32'(bus.sum),   32'd3);
        bus.req1 = 1'b0;
        step();
        step();

        // Operand changes after latching must not reach the sum
        bus.a1 = 4'h6; bus.b1 = 4'h1;
        bus.req1 = 1'b1;
        step();
        bus.a1 = 4'hF;
        step();
        check("stab_sum_calc", 32'(bus.sum), 32'd7);
        bus.b1 = 4'hF;
        step();
        check("stab_sum_done", 32'(bus.sum),  32'd7);
        check("stab_cout",     32'(bus.cout), 32'd0);
        bus.req1 = 1'b0;
        step();
        step();

        // Asynchronous reset during CALC aborts the transaction
        bus.a0 = 4'h3; bus.b0 = 4'h3;
        bus.req0 = 1'b1;
        step();
        check("rst_pre_gnt0", 32'(bus.gnt0), 32'd1);
        resetn = 1'b0;
        #1;
        check_idle_outputs("rst_async");
        check("rst_async_sum",  32'(bus.sum),     32'd0);
        check("rst_async_cout", 32'(bus.cout),    32'd0);
        check("rst_async_seg",  32'(bus.seg_out), 32'b1000000);
        step();
        check("rst_held_done0", 32'(bus.done0), 32'd0);
        bus.req0 = 1'b0;
        resetn = 1'b1;
        step();
        step();
        check_idle_outputs("rst_after");
        check("rst_after_sum", 32'(bus.sum), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/adder_share_ctrl.md
ADDER_SHARE_CTRL -- requirements
Module: adder_share_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: resetn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: req0, req1  input  1 each  request from requester 0 / 1, 4-phase handshake.
REQ-004 SHALL have ports: a0, b0, a1, b1  input  4 each  operands of requester 0 / 1, held stable while req high.
REQ-005 SHALL have ports: gnt0, gnt1  output  1 each  registered grant, at most one high.
REQ-006 SHALL have ports: done0, done1  output  1 each  registered result-valid to granted requester.
REQ-007 SHALL have ports: sum  output  4  registered result; cout  output  1  registered carry-out.
REQ-008 SHALL have port: seg_out  output  7  active-low 7-segment pattern of sum, bit0 = segment a … bit6 = segment g.

Function
REQ-009 SHALL implement FSM states IDLE, CALC, DONE; one 4-bit adder shared by both requesters.
REQ-010 IDLE: any req high at clock edge -> latch winner's operands, set winner's gnt, go CALC.
REQ-011 Arbitration SHALL be round-robin: single requester wins; both high -> requester other than last_served wins; last_served resets to 1 (requester 0 wins first tie).
REQ-012 CALC: register {cout,sum} = 5-bit sum of latched operands with carry-in 0; set winner's done; go DONE.
REQ-013 DONE: hold gnt and done high while winner's req high; winner's req low at edge -> clear gnt and done, update last_served, go IDLE.
REQ-014 Latency: req high at edge k -> gnt high after edge k, done/sum valid after edge k+1; one-cycle minimum IDLE between transactions.
REQ-015 Losing requester SHALL be ignored until FSM returns to IDLE; its req is not queued beyond being high.
REQ-016 Winner dropping req during CALC SHALL still complete: done high exactly one cycle, then IDLE.
REQ-017 Operand changes after latching in IDLE SHALL NOT affect sum.
REQ-018 sum and cout SHALL hold last result until next CALC; seg_out SHALL be combinational decode of sum (0->1000000, 5->0010010, 8->0000000, F->0001110).

Reset
REQ-019 resetn low SHALL immediately force IDLE, gnt0=gnt1=done0=done1=0, sum=0, cout=0, seg_out=7'b1000000, last_served=1.
REQ-020 Reset mid-transaction SHALL abort with no done pulse; operation is not resumed after release.

Configuration
REQ-021 ADD_SAT_EN defined: when carry-out is 1, sum SHALL be 4'hF and cout 1.
REQ-022 ADD_SAT_EN undefined: sum SHALL be low 4 bits of result (wrap), cout carries bit 4.

Structure
REQ-023 Shared package SHALL hold FSM state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2), operand width 4, and segment pattern constants.
REQ-024 7-segment decode SHALL be sub-module seg7_decode (4-bit in, 7-bit active-low out), instantiated once.

Verification
REQ-025 Reset: assert resetn=0 mid-CALC -> all outputs 0, seg_out=7'b1000000 asynchronously, no done.
REQ-026 Single: req0=1, a0=3, b0=2 at edge k -> gnt0 after k, done0=1, sum=5, cout=0, seg_out=7'b0010010 after k+1.
REQ-027 Tie: req0=req1=1 held after reset -> requester 0 served first; after req0 drop, requester 1 granted next; gnt never both high.
REQ-028 Overflow: a1=9, b1=8 -> sum=1, cout=1 without ADD_SAT_EN; sum=F, cout=1, seg_out=7'b0001110 with it.
REQ-029 Early drop: req0 low during CALC -> done0 high one cycle, FSM IDLE next cycle, pending req1 granted.
REQ-030 Operand stability: change a0 during CALC/DONE -> sum unchanged from latched operands.
